// File: rtl/irq_pending_prio.sv
// Request capture, masking and highest-index arbitration feeding a valid/ready consumer.
// Build option: define IRQ_EDGE_EN for rising-edge capture with a sticky overflow flag.
module irq_pending_prio #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned CODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic              mask_we,
    input  logic [N_REQ-1:0]  mask_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_none,
    output logic [N_REQ-1:0]  pending,
    output logic              ovf,
    input  logic              ovf_clr
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [N_REQ-1:0]    mask_q, mask_d;
    logic                out_valid_q, out_valid_d;
    logic [CODE_W-1:0]   out_code_q, out_code_d;
    logic                out_none_q, out_none_d;
    logic                ovf_q, ovf_d;

    logic [N_REQ-1:0]    set_vec;
    logic [N_REQ-1:0]    clr_vec;
    logic [N_REQ-1:0]    cand;
    logic [CODE_W-1:0]   sel_idx;
    logic                hs;

`ifdef IRQ_EDGE_EN
    logic [N_REQ-1:0]    req_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_d_q <= '0;
        end else begin
            req_d_q <= req;
        end
    end

    assign set_vec = req & ~req_d_q;
`else
    assign set_vec = req;
`endif

    assign hs      = (state_q == PRESENT) && out_valid_q && out_ready;
    assign clr_vec = hs ? (N_REQ'(1) << out_code_q) : '0;
    assign cand    = pending_q & mask_q;

    // Highest-numbered candidate wins, matching the downstream encoder.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (cand[i]) begin
                sel_idx = CODE_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        mask_d      = mask_we ? mask_wdata : mask_q;
        // Set is ORed in last so a same-cycle set survives the handshake clear.
        pending_d   = (pending_q & ~clr_vec) | set_vec;
        out_none_d  = en && (state_q == IDLE) && (cand == '0);
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (en && (cand != '0)) begin
                    out_code_d  = sel_idx;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

`ifdef IRQ_EDGE_EN
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if ((set_vec & pending_q & ~clr_vec) != '0) begin
            ovf_d = 1'b1;
        end
`else
        ovf_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            mask_q      <= '1;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_none_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_none_q  <= out_none_d;
            ovf_q       <= ovf_d;
        end
    end

`ifndef IRQ_EDGE_EN
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_none  = out_none_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule
